raster_sequencer: RTL and testbench

- Bus master that feeds triangle descriptors into the video rasterizer's MMIO register block.
- Accepts 14-word descriptors on a valid/ready stream and writes them to rasterizer registers 3..16 in order.
- Optionally waits for vertical blank, issues start, then polls busy until the rasterizer finishes.
- Sits between the CPU-side command queue and the Video block's bus port, so the CPU no longer hand-sequences triangle setup.

---
 rtl/video_pkg.sv | 38 +++
 rtl/raster_bus_master.sv | 65 ++++++
 rtl/raster_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_raster_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the rasterizer command path: MMIO register map of the
// Video block, descriptor geometry and the sequencer state encoding.
package video_pkg;

    // Rasterizer MMIO register addresses (word addresses on the Video bus)
    localparam int unsigned V_BLANK    = 0;
    localparam int unsigned START      = 1;
    localparam int unsigned BUSY       = 2;
    localparam int unsigned X_MIN      = 3;
    localparam int unsigned X_MAX      = 4;
    localparam int unsigned Y_MIN      = 5;
    localparam int unsigned Y_MAX      = 6;
    localparam int unsigned RECIPROCAL = 7;
    localparam int unsigned IW_0       = 8;
    localparam int unsigned IW_1       = 9;
    localparam int unsigned IW_2       = 10;
    localparam int unsigned DC_0       = 11;
    localparam int unsigned DC_1       = 12;
    localparam int unsigned DC_2       = 13;
    localparam int unsigned DR_0       = 14;
    localparam int unsigned DR_1       = 15;
    localparam int unsigned DR_2       = 16;

    // A triangle descriptor covers X_MIN..DR_2 one word per register
    localparam int unsigned DESC_WORDS = 14;
    localparam int unsigned IDX_BITS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BLANK,
        ST_WRITE,
        ST_START,
        ST_POLL,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/raster_bus_master.sv
// Single-access master for the Video bus: turns a one-cycle request into a
// one-cycle strobe, holds address/data/direction until the slave answers, and
// reissues the strobe whenever the slave asks for a retry.
module raster_bus_master #(
    parameter int unsigned ADDR_BITS      = 11,
    parameter int unsigned WORD_BITS      = 32,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_i,
    input  logic [ADDR_BITS-1:0]      addr_i,
    input  logic [WORD_BITS-1:0]      wdata_i,
    input  logic                      write_i,
    output logic                      done_o,
    output logic [WORD_BITS-1:0]      rdata_o,
    output logic [ADDR_BITS-1:0]      busAddr_o,
    output logic [WORD_BITS-1:0]      busOut_o,
    input  logic [WORD_BITS-1:0]      busIn_i,
    output logic [BYTES_PER_WORD-1:0] busSelect_o,
    output logic                      busWrite_o,
    output logic                      busStrobe_o,
    input  logic                      busAck_i,
    input  logic                      busRetry_i
);

    logic                 pending_q;
    logic                 strobe_q;
    logic                 write_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_BITS-1:0] out_q;

    // An answer is only meaningful after the strobe cycle; ack wins over retry
    assign done_o      = pending_q && !strobe_q && busAck_i;
    assign rdata_o     = busIn_i;
    assign busSelect_o = '1;
    assign busAddr_o   = addr_q;
    assign busOut_o    = out_q;
    assign busWrite_o  = write_q;
    assign busStrobe_o = strobe_q;

    // Access sequencing: launch, drop strobe after one cycle, wait for ack or retry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            strobe_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            out_q     <= '0;
        end else if (req_i) begin
            addr_q    <= addr_i;
            out_q     <= wdata_i;
            write_q   <= write_i;
            strobe_q  <= 1'b1;
            pending_q <= 1'b1;
        end else if (strobe_q) begin
            strobe_q  <= 1'b0;
        end else if (done_o) begin
            pending_q <= 1'b0;
        end else if (pending_q && busRetry_i) begin
            strobe_q  <= 1'b1;
        end
    end

endmodule

// File: rtl/raster_sequencer.sv
// Feeds triangle descriptors from the command stream into the rasterizer:
// buffers 14 words, optionally waits for vertical blank, writes the register
// block, kicks START and polls BUSY until the triangle is finished.
module raster_sequencer
    import video_pkg::*;
#(
    parameter  int unsigned ADDR_BITS      = 11,
    parameter  int unsigned BYTE_BITS      = 8,
    parameter  int unsigned BYTES_PER_WORD = 4,
    parameter  int unsigned FIRST_REG      = 3,
    localparam int unsigned WORD_BITS      = BYTE_BITS * BYTES_PER_WORD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WORD_BITS-1:0]      cmd_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      wait_blank,
    output logic [ADDR_BITS-1:0]      addr,
    output logic [WORD_BITS-1:0]      out,
    input  logic [WORD_BITS-1:0]      in,
    output logic [BYTES_PER_WORD-1:0] select,
    output logic                      write,
    output logic                      strobe,
    input  logic                      ack,
    input  logic                      retry,
    output logic                      busy,
    output logic [15:0]               done_count
);

    seq_state_e           state_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic                 cmdReady_q;
    logic                 busy_q;
    logic [15:0]          doneCount_q;
    logic [WORD_BITS-1:0] desc_q [DESC_WORDS];

    logic                 accept;
    logic                 lastWord;
    logic [IDX_BITS-1:0]  idxNext;
    logic                 accDone;
    logic [WORD_BITS-1:0] accRdata;
    logic                 flagSet;
    logic                 issueReq;
    logic                 issueWrite;
    logic [ADDR_BITS-1:0] issueAddr;
    logic [WORD_BITS-1:0] issueWdata;

    assign accept     = cmd_valid && cmdReady_q;
    assign lastWord   = (idx_q == IDX_BITS'(DESC_WORDS - 1));
    assign idxNext    = idx_q + IDX_BITS'(1);
    assign flagSet    = (accRdata & WORD_BITS'(1)) != '0;
    assign cmd_ready  = cmdReady_q;
    assign busy       = busy_q;
    assign done_count = doneCount_q;

    raster_bus_master #(
        .ADDR_BITS      (ADDR_BITS),
        .WORD_BITS      (WORD_BITS),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_bus (
        .clock       (clock),
        .reset       (reset),
        .req_i       (issueReq),
        .addr_i      (issueAddr),
        .wdata_i     (issueWdata),
        .write_i     (issueWrite),
        .done_o      (accDone),
        .rdata_o     (accRdata),
        .busAddr_o   (addr),
        .busOut_o    (out),
        .busIn_i     (in),
        .busSelect_o (select),
        .busWrite_o  (write),
        .busStrobe_o (strobe),
        .busAck_i    (ack),
        .busRetry_i  (retry)
    );

    // Next bus access, launched on the same edge the previous one completes
    always_comb begin
        issueReq   = 1'b0;
        issueWrite = 1'b0;
        issueAddr  = '0;
        issueWdata = '0;
        case (state_q)
            ST_LOAD: begin
                if (accept && lastWord) begin
                    issueReq = 1'b1;
                    if (wait_blank) begin
                        issueAddr = ADDR_BITS'(V_BLANK);
                    end else begin
                        issueWrite = 1'b1;
                        issueAddr  = ADDR_BITS'(FIRST_REG);
                        issueWdata = desc_q[0];
                    end
                end
            end
            ST_BLANK: begin
                if (accDone) begin
                    issueReq = 1'b1;
                    if (flagSet) begin
                        issueWrite = 1'b1;
                        issueAddr  = ADDR_BITS'(FIRST_REG);
                        issueWdata = desc_q[0];
                    end else begin
                        issueAddr = ADDR_BITS'(V_BLANK);
                    end
                end
            end
            ST_WRITE: begin
                if (accDone) begin
                    issueReq   = 1'b1;
                    issueWrite = 1'b1;
                    if (lastWord) begin
                        issueAddr  = ADDR_BITS'(START);
                        issueWdata = WORD_BITS'(1);
                    end else begin
                        issueAddr  = ADDR_BITS'(FIRST_REG) + ADDR_BITS'(idxNext);
                        issueWdata = desc_q[idxNext];
                    end
                end
            end
            ST_START: begin
                if (accDone) begin
                    issueReq  = 1'b1;
                    issueAddr = ADDR_BITS'(BUSY);
                end
            end
            ST_POLL: begin
                if (accDone && flagSet) begin
                    issueReq  = 1'b1;
                    issueAddr = ADDR_BITS'(BUSY);
                end
            end
            default: begin
                issueReq = 1'b0;
            end
        endcase
    end

    // Descriptor buffer: captures each accepted command word at the current index
    always_ff @(posedge clock) begin
        if (accept) begin
            desc_q[idx_q] <= cmd_data;
        end
    end

    // Sequencer FSM with registered handshake, busy and completion counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cmdReady_q  <= 1'b0;
            busy_q      <= 1'b0;
            doneCount_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_LOAD;
                    cmdReady_q <= 1'b1;
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (lastWord) begin
                            idx_q      <= '0;
                            cmdReady_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= wait_blank ? ST_BLANK : ST_WRITE;
                        end else begin
                            idx_q <= idxNext;
                        end
                    end
                end
                ST_BLANK: begin
                    if (accDone && flagSet) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (accDone) begin
                        if (lastWord) begin
                            idx_q   <= '0;
                            state_q <= ST_START;
                        end else begin
                            idx_q <= idxNext;
                        end
                    end
                end
                ST_START: begin
                    if (accDone) begin
                        state_q <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (accDone && !flagSet) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    doneCount_q <= doneCount_q + 16'd1;
                    cmdReady_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench for raster_sequencer: a slave model answers bus accesses and
// compares each strobe against a scoreboard of expected register accesses.
module tb_raster_sequencer;

    localparam int ADDR_BITS = 11;
    localparam int WORD_BITS = 32;
    localparam int FIRST_REG = 3;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 write;
        logic [WORD_BITS-1:0] data;
    } access_t;

    logic                 clock;
    logic                 reset;
    logic [WORD_BITS-1:0] cmd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 wait_blank;
    logic [ADDR_BITS-1:0] addr;
    logic [WORD_BITS-1:0] out;
    logic [WORD_BITS-1:0] in;
    logic [3:0]           select;
    logic                 write;
    logic                 strobe;
    logic                 ack;
    logic                 retry;
    logic                 busy;
    logic [15:0]          done_count;

    access_t        expQ[$];
    logic [31:0]    blankQ[$];
    logic [31:0]    busyQ[$];
    int             checkCount = 0;
    int             passCount  = 0;
    int             retryAddr  = -1;
    int             retryLeft  = 0;
    int             pollReads  = 0;
    bit             respDue    = 0;
    bit             prevStrobe = 0;
    logic [ADDR_BITS-1:0] pendAddr;
    logic           pendWrite;

    raster_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .wait_blank (wait_blank),
        .addr       (addr),
        .out        (out),
        .in         (in),
        .select     (select),
        .write      (write),
        .strobe     (strobe),
        .ack        (ack),
        .retry      (retry),
        .busy       (busy),
        .done_count (done_count)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic access_t mkAccess(input int a, input bit w, input logic [31:0] d);
        access_t r;
        r.addr  = ADDR_BITS'(a);
        r.write = w;
        r.data  = d;
        return r;
    endfunction

    // Queue the bus accesses one descriptor must produce, in order
    task automatic expectDescriptor(input logic [31:0] base, input int blankReads, input int retries, input int busyReads);
        for (int k = 0; k < blankReads; k++) expQ.push_back(mkAccess(0, 1'b0, 32'h0));
        for (int i = 0; i < 14; i++) begin
            int reps;
            reps = ((FIRST_REG + i) == retryAddr) ? retries + 1 : 1;
            for (int r = 0; r < reps; r++) expQ.push_back(mkAccess(FIRST_REG + i, 1'b1, base + 32'(i)));
        end
        expQ.push_back(mkAccess(1, 1'b1, 32'h1));
        for (int k = 0; k < busyReads; k++) expQ.push_back(mkAccess(2, 1'b0, 32'h0));
    endtask

    // Drive one 14-word descriptor, optionally with gaps in cmd_valid
    task automatic applyStimulus(input logic [31:0] base, input bit wb, input bit toggle,
                                 input int blankReads, input int retries, input int busyReads);
        int guard;
        wait_blank = wb;
        for (int i = 0; i < 14; i++) begin
            if (toggle) begin
                cmd_valid = 1'b0;
                cmd_data  = 32'hDEAD_0000 | 32'(i);
                @(posedge clock); #1;
            end
            if (i == 13) expectDescriptor(base, blankReads, retries, busyReads);
            cmd_data  = base + 32'(i);
            cmd_valid = 1'b1;
            guard = 0;
            while (cmd_ready !== 1'b1 && guard < 200) begin
                @(posedge clock); #1;
                guard++;
            end
            if (guard >= 200) checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'h1);
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        checkOutput("ready_after_last", 32'(cmd_ready), 32'h0);
        checkOutput("busy_after_last", 32'(busy), 32'h1);
    endtask

    // Wait, bounded, for the sequencer to drain and come back to LOAD
    task automatic waitDone(input string tag);
        int guard;
        guard = 0;
        while (!(expQ.size() == 0 && busy === 1'b0 && cmd_ready === 1'b1) && guard < 2000) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput({tag, "_idle"}, {30'h0, busy, cmd_ready}, 32'h1);
        checkOutput({tag, "_sb_left"}, 32'(expQ.size()), 32'h0);
    endtask

    // Slave model: answers each strobe one cycle later and checks it against the scoreboard
    initial begin
        access_t e;
        ack = 1'b0;
        retry = 1'b0;
        in = '0;
        forever begin
            @(posedge clock); #1;
            ack   = 1'b0;
            retry = 1'b0;
            if (reset) begin
                respDue    = 0;
                prevStrobe = 0;
            end else begin
                if (respDue) begin
                    respDue = 0;
                    if (pendWrite) begin
                        if (int'(pendAddr) == retryAddr && retryLeft > 0) begin
                            retryLeft--;
                            retry = 1'b1;
                        end else begin
                            ack = 1'b1;
                        end
                    end else begin
                        if (pendAddr == 0) begin
                            in = (blankQ.size() > 0) ? blankQ.pop_front() : 32'h1;
                        end else begin
                            in = (busyQ.size() > 0) ? busyQ.pop_front() : 32'h0;
                            pollReads++;
                        end
                        ack = 1'b1;
                    end
                end
                if (strobe) begin
                    checkOutput("strobe_single_cycle", 32'(prevStrobe), 32'h0);
                    if (expQ.size() == 0) begin
                        checkOutput("strobe_expected", 32'(expQ.size() > 0), 32'h1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("bus_addr", 32'(addr), 32'(e.addr));
                        checkOutput("bus_write", 32'(write), 32'(e.write));
                        if (e.write) checkOutput("bus_data", out, e.data);
                    end
                    pendAddr  = addr;
                    pendWrite = write;
                    respDue   = 1;
                end
                prevStrobe = strobe;
            end
        end
    end

    // Directed test sequence
    initial begin
        int guard;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        wait_blank = 1'b0;
        #12;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("rst_strobe", 32'(strobe), 32'h0);
        checkOutput("rst_write", 32'(write), 32'h0);
        checkOutput("rst_addr", 32'(addr), 32'h0);
        checkOutput("rst_out", out, 32'h0);
        checkOutput("rst_select", 32'(select), 32'hF);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done_count", 32'(done_count), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] basic descriptor, no blank wait");
        busyQ = {32'h1, 32'h1, 32'h0};
        pollReads = 0;
        applyStimulus(32'h100, 1'b0, 1'b0, 0, 0, 3);
        waitDone("t1");
        checkOutput("t1_done_count", 32'(done_count), 32'h1);
        checkOutput("t1_poll_reads", 32'(pollReads), 32'h3);

        $display("[TB] wait for vertical blank");
        blankQ = {32'h0, 32'h0, 32'h1};
        busyQ  = {32'h0};
        applyStimulus(32'h100, 1'b1, 1'b0, 3, 0, 1);
        waitDone("t2");
        checkOutput("t2_done_count", 32'(done_count), 32'h2);

        $display("[TB] retry on register 9");
        retryAddr = 9;
        retryLeft = 2;
        busyQ = {32'h0};
        applyStimulus(32'h300, 1'b0, 1'b0, 0, 2, 1);
        waitDone("t3");
        checkOutput("t3_retries_used", 32'(retryLeft), 32'h0);
        checkOutput("t3_done_count", 32'(done_count), 32'h3);
        retryAddr = -1;

        $display("[TB] cmd_valid toggling");
        busyQ = {32'h0};
        applyStimulus(32'h200, 1'b0, 1'b1, 0, 0, 1);
        waitDone("t4");
        checkOutput("t4_done_count", 32'(done_count), 32'h4);

        $display("[TB] reset during busy polling");
        busyQ.delete();
        for (int k = 0; k < 60; k++) busyQ.push_back(32'h1);
        pollReads = 0;
        applyStimulus(32'h400, 1'b0, 1'b0, 0, 0, 60);
        guard = 0;
        while (pollReads < 2 && guard < 500) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("t5_polling", 32'(pollReads >= 2), 32'h1);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        checkOutput("t5_strobe", 32'(strobe), 32'h0);
        checkOutput("t5_busy", 32'(busy), 32'h0);
        checkOutput("t5_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("t5_addr", 32'(addr), 32'h0);
        checkOutput("t5_write", 32'(write), 32'h0);
        checkOutput("t5_out", out, 32'h0);
        checkOutput("t5_done_count", 32'(done_count), 32'h0);
        expQ.delete();
        busyQ.delete();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        busyQ = {32'h0};
        applyStimulus(32'h500, 1'b0, 1'b0, 0, 0, 1);
        waitDone("t5b");
        checkOutput("t5b_done_count", 32'(done_count), 32'h1);

        $display("[TB] completion counter wrap");
        force dut.doneCount_q = 16'hFFFF;
        @(posedge clock); #1;
        release dut.doneCount_q;
        busyQ = {32'h0};
        applyStimulus(32'h600, 1'b0, 1'b0, 0, 0, 1);
        waitDone("t6");
        checkOutput("t6_done_wrap", 32'(done_count), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
